i2c_target_regs: RTL and testbench

- Synthesizable I2C target (slave) holding a small byte-wide register file; the bus responder paired with the existing I2C initiator in `top`.
- Lets the codec-configuration initiator run in closed loop on FPGA/sim without the behavioural slave model, and exposes the written registers to fabric.
- Sits on the same open-drain SCL/SDA lines; SCL is input-only (no clock stretching).

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_bus_sync.sv | 49 ++++
 rtl/i2c_target_regs.sv | 204 ++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus-level ACK/NACK values, the default MAX9850
// target address, and the target-side protocol state encoding.
package i2c_pkg;

    localparam logic       I2C_ACK      = 1'b0;
    localparam logic       I2C_NACK     = 1'b1;
    localparam logic [6:0] MAX9850_ADDR = 7'h10;

    // Target protocol states. Each received byte has its own ACK state so the
    // state itself says where to go after the ACK clock.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_PTR,
        ST_PTR_ACK,
        ST_WR_DATA,
        ST_DATA_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C pin conditioning: 2-FF synchronizers on SCL and SDA, plus SCL edge and
// START/STOP detection on the synchronized levels. Events are single-cycle
// combinational strobes derived from the synchronized and previous values.
module i2c_bus_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda_s
);

    logic [1:0] scl_ff;
    logic [1:0] sda_ff;
    logic       scl_s;
    logic       scl_p;
    logic       sda_p;

    assign scl_s = scl_ff[1];
    assign sda_s = sda_ff[1];

    // Synchronize both pins and keep the previous synchronized level for edge
    // detection; reset to an idle (released, high) bus so no event fires.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_ff <= 2'b11;
            sda_ff <= 2'b11;
            scl_p  <= 1'b1;
            sda_p  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the old
            // value of its neighbour, which is what turns this into a shift chain.
            scl_ff <= {scl_ff[0], scl_pin};
            sda_ff <= {sda_ff[0], sda_pin};
            scl_p  <= scl_s;
            sda_p  <= sda_s;
        end
    end

    assign scl_rise = scl_s & ~scl_p;
    assign scl_fall = ~scl_s & scl_p;
    // SDA moving while SCL is stably high is a bus condition, never data.
    assign start    = scl_s & scl_p & sda_p & ~sda_s;
    assign stop     = scl_s & scl_p & ~sda_p & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target with a byte-wide register file. First written byte after the
// address sets the register pointer; further written bytes store at the
// pointer and auto-increment it. Reads return bytes from the pointer, also
// auto-incrementing. SCL is input-only; SDA is driven open-drain via OE.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = MAX9850_ADDR,
    parameter int         NUM_REGS = 16,
    parameter int         PTR_W    = $clog2(NUM_REGS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  I2C_SCL,
    input  logic                  I2C_SDA_I,
    output logic                  I2C_SDA_O,
    output logic                  I2C_SDA_OE,
    output logic [8*NUM_REGS-1:0] o_regs,
    output logic                  o_wr_stb,
    output logic [PTR_W-1:0]      o_wr_addr,
    output logic [7:0]            o_wr_data,
    output logic                  o_busy
);

    logic scl_rise, scl_fall, start, stop, sda_s;

    i2c_bus_sync u_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .scl_pin (I2C_SCL),
        .sda_pin (I2C_SDA_I),
        .scl_rise(scl_rise),
        .scl_fall(scl_fall),
        .start   (start),
        .stop    (stop),
        .sda_s   (sda_s)
    );

    state_t           state, state_n;
    logic [3:0]       cnt, cnt_n;     // bits received / driven in current byte
    logic [7:0]       sh, sh_n;       // receive or transmit shift register
    logic [PTR_W-1:0] ptr, ptr_n;
    logic             rw, rw_n;
    logic             oe, oe_n;
    logic             busy, busy_n;
    logic             we;
    logic [7:0]       byte_in;
    logic [7:0]       rd_byte;
    logic [7:0]       regs [NUM_REGS];

    assign byte_in = {sh[6:0], sda_s};
    assign rd_byte = regs[ptr];

    // Next-state and datapath decisions, driven by the bus events.
    always_comb begin
        // NOTE: every target gets a hold default first so no path through the
        // branches below leaves a variable unassigned and infers a latch.
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        ptr_n   = ptr;
        rw_n    = rw;
        oe_n    = oe;
        busy_n  = busy;
        we      = 1'b0;

        if (stop) begin
            state_n = ST_IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else if (start) begin
            state_n = ST_ADDR;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
        end else begin
            case (state)
                ST_ADDR, ST_WR_PTR, ST_WR_DATA: begin
                    if (scl_rise && cnt != 4'd8) begin
                        sh_n  = byte_in;
                        cnt_n = cnt + 4'd1;
                        if (cnt == 4'd7) begin
                            if (state == ST_ADDR) begin
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    busy_n = 1'b1;
                                    rw_n   = byte_in[0];
                                end else begin
                                    state_n = ST_IGNORE;
                                end
                            end else if (state == ST_WR_PTR) begin
                                ptr_n = byte_in[PTR_W-1:0];
                            end else begin
                                we    = 1'b1;
                                ptr_n = ptr + PTR_W'(1);
                            end
                        end
                    end else if (scl_fall && cnt == 4'd8) begin
                        oe_n = 1'b1;
                        if (state == ST_ADDR)        state_n = ST_ADDR_ACK;
                        else if (state == ST_WR_PTR) state_n = ST_PTR_ACK;
                        else                         state_n = ST_DATA_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!rw) begin
                            oe_n    = 1'b0;
                            cnt_n   = 4'd0;
                            state_n = ST_WR_PTR;
                        end else begin
                            // First data bit goes out on the same falling edge
                            // that ends the ACK clock.
                            oe_n    = ~rd_byte[7];
                            sh_n    = {rd_byte[6:0], 1'b0};
                            cnt_n   = 4'd1;
                            ptr_n   = ptr + PTR_W'(1);
                            state_n = ST_RD_DATA;
                        end
                    end
                end
                ST_PTR_ACK, ST_DATA_ACK: begin
                    if (scl_fall) begin
                        oe_n    = 1'b0;
                        cnt_n   = 4'd0;
                        state_n = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall) begin
                        if (cnt != 4'd8) begin
                            oe_n  = ~sh[7];
                            sh_n  = {sh[6:0], 1'b0};
                            cnt_n = cnt + 4'd1;
                        end else begin
                            oe_n    = 1'b0;
                            state_n = ST_RD_ACK;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            sh_n    = rd_byte;
                            cnt_n   = 4'd0;
                            ptr_n   = ptr + PTR_W'(1);
                            state_n = ST_RD_DATA;
                        end else begin
                            state_n = ST_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Protocol state and control registers; OE clears asynchronously on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
            sh    <= 8'h00;
            ptr   <= '0;
            rw    <= 1'b0;
            oe    <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sh    <= sh_n;
            ptr   <= ptr_n;
            rw    <= rw_n;
            oe    <= oe_n;
            busy  <= busy_n;
        end
    end

    // Register file and the write strobe that reports each committed byte.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: the register file is visible to fabric, so it is reset
            // explicitly instead of being left as uninitialized storage.
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= 8'h00;
            o_wr_stb  <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= 8'h00;
        end else begin
            o_wr_stb <= we;
            if (we) begin
                regs[ptr] <= byte_in;
                o_wr_addr <= ptr;
                o_wr_data <= byte_in;
            end
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign o_regs[8*k +: 8] = regs[k];
    end

    assign I2C_SDA_O  = 1'b0;
    assign I2C_SDA_OE = oe;
    assign o_busy     = busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C initiator, a transaction-level
// register model, and a write-strobe scoreboard checked by its own monitor.
module tb_i2c_target_regs;
    import i2c_pkg::*;

    localparam int         NUM_REGS = 16;
    localparam int         PTR_W    = 4;
    localparam logic [6:0] DEV      = 7'h10;
    localparam int         Q        = 4;   // i_clk cycles per SCL quarter period

    logic                  i_clk = 1'b0;
    logic                  i_rst;
    logic                  scl;
    logic                  sda_tb;
    logic                  sda_line;
    logic                  sda_o;
    logic                  oe;
    logic [8*NUM_REGS-1:0] regs_flat;
    logic                  stb;
    logic [PTR_W-1:0]      wr_addr;
    logic [7:0]            wr_data;
    logic                  busy;

    assign sda_line = sda_tb & ~oe;   // open-drain wired-AND

    always #5 i_clk = ~i_clk;

    i2c_target_regs #(.DEV_ADDR(DEV), .NUM_REGS(NUM_REGS)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .I2C_SCL   (scl),
        .I2C_SDA_I (sda_line),
        .I2C_SDA_O (sda_o),
        .I2C_SDA_OE(oe),
        .o_regs    (regs_flat),
        .o_wr_stb  (stb),
        .o_wr_addr (wr_addr),
        .o_wr_data (wr_data),
        .o_busy    (busy)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mregs [NUM_REGS];
    int          mptr;
    logic [11:0] exp_q [$];     // expected {addr, data} per write strobe
    logic [7:0]  tx_buf [$];
    logic        oe_seen;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f = '0;
        for (int k = 0; k < NUM_REGS; k++) f[8*k +: 8] = mregs[k];
        return f;
    endfunction

    // Scoreboard monitor: every strobe must match the oldest expected write.
    always @(negedge i_clk) begin
        if (oe) oe_seen = 1'b1;
        if (stb) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stb_unexpected: addr %0d data 0x%0h, none expected", wr_addr, wr_data);
            end else begin
                check("wr_stb", {wr_addr, wr_data}, exp_q.pop_front());
            end
        end
    end

    task automatic ticks(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic write_bit(input logic b);
        ticks(Q); sda_tb = b; ticks(Q); scl = 1'b1; ticks(2*Q); scl = 1'b0;
    endtask

    task automatic read_bit(output logic r);
        ticks(Q); sda_tb = 1'b1; ticks(Q); scl = 1'b1; ticks(Q);
        r = sda_line;
        ticks(Q); scl = 1'b0;
    endtask

    task automatic bus_start();
        ticks(Q); sda_tb = 1'b1; ticks(Q); scl = 1'b1; ticks(2*Q);
        sda_tb = 1'b0; ticks(2*Q); scl = 1'b0;
    endtask

    // STOP, then check o_busy is still at its transaction value two edges
    // after the SDA rise and low on the third.
    task automatic bus_stop(input logic exp_busy);
        ticks(Q); sda_tb = 1'b0; ticks(Q); scl = 1'b1; ticks(2*Q);
        sda_tb = 1'b1;
        @(posedge i_clk); @(posedge i_clk); #1;
        check("busy_pre_stop", busy, exp_busy);
        @(posedge i_clk); #1;
        check("busy_post_stop", busy, 1'b0);
        ticks(2*Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            read_bit(r);
            d[i] = r;
        end
        write_bit(ack);
    endtask

    // START, dev, tx_buf[0..n-1], STOP. First byte is the pointer.
    task automatic wr_txn(input logic [7:0] dev, input int n);
        logic ack;
        logic match;
        match = (dev[7:1] == DEV) && !dev[0];
        bus_start();
        write_byte(dev, ack);
        check("addr_ack", ack, match ? I2C_ACK : I2C_NACK);
        check("busy_after_addr", busy, match);
        for (int i = 0; i < n; i++) begin
            if (match) begin
                if (i == 0) begin
                    mptr = tx_buf[0] % NUM_REGS;
                end else begin
                    mregs[mptr] = tx_buf[i];
                    exp_q.push_back({4'(mptr), tx_buf[i]});
                    mptr = (mptr + 1) % NUM_REGS;
                end
            end
            write_byte(tx_buf[i], ack);
            check("data_ack", ack, match ? I2C_ACK : I2C_NACK);
        end
        bus_stop(match);
        check("regs", regs_flat, model_flat());
    endtask

    // Read n bytes from the current pointer: ACK all but the last, NACK it,
    // then confirm the target stays off the bus until STOP.
    task automatic read_n(input int n);
        logic [7:0] d;
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            e    = mregs[mptr];
            mptr = (mptr + 1) % NUM_REGS;
            read_byte((i == n - 1) ? I2C_NACK : I2C_ACK, d);
            check("rd_data", d, e);
        end
        oe_seen = 1'b0;
        write_bit(1'b1);
        bus_stop(1'b1);
        check("oe_after_nack", oe_seen, 1'b0);
    endtask

    // Set pointer, repeated START, read.
    task automatic rd_txn(input logic [7:0] p, input int n);
        logic ack;
        bus_start();
        write_byte({DEV, 1'b0}, ack);
        check("rd_addr_w_ack", ack, I2C_ACK);
        write_byte(p, ack);
        check("rd_ptr_ack", ack, I2C_ACK);
        mptr = p % NUM_REGS;
        bus_start();
        write_byte({DEV, 1'b1}, ack);
        check("rd_addr_r_ack", ack, I2C_ACK);
        read_n(n);
    endtask

    // Read from wherever the pointer was left.
    task automatic rd_cur(input int n);
        logic ack;
        bus_start();
        write_byte({DEV, 1'b1}, ack);
        check("cur_addr_ack", ack, I2C_ACK);
        read_n(n);
    endtask

    initial begin
        #800000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ack;
        int   waited;
        i_rst  = 1'b1;
        scl    = 1'b1;
        sda_tb = 1'b1;
        mptr   = 0;
        for (int k = 0; k < NUM_REGS; k++) mregs[k] = 8'h00;
        ticks(3);
        check("rst_oe", oe, 1'b0);
        check("rst_sda_o", sda_o, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_stb", stb, 1'b0);
        check("rst_regs", regs_flat, '0);
        i_rst = 1'b0;
        ticks(5);

        // Single write to register 10.
        tx_buf = '{8'h0A, 8'h5C};
        wr_txn(8'h20, 2);
        check("reg10", regs_flat[87:80], 8'h5C);

        // Burst crossing the top of the register file.
        tx_buf = '{8'h0F, 8'h11, 8'h22};
        wr_txn(8'h20, 3);
        check("reg15", regs_flat[127:120], 8'h11);
        check("reg0", regs_flat[7:0], 8'h22);

        // Read back through a repeated START: reg10, then reg11.
        rd_txn(8'h0A, 2);

        // Wrong address: NACKed, ignored, SDA never driven.
        tx_buf  = '{8'hFF};
        oe_seen = 1'b0;
        wr_txn(8'h22, 1);
        check("wrong_addr_oe", oe_seen, 1'b0);

        // Pointer-only write, then a current-address read across the wrap.
        tx_buf = '{8'h0F};
        wr_txn(8'h20, 1);
        rd_cur(2);

        // Randomized traffic against the model.
        repeat (20) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    tx_buf.delete();
                    tx_buf.push_back(8'($urandom_range(0, 255)));
                    for (int i = 0; i < int'($urandom_range(1, 4)); i++)
                        tx_buf.push_back(8'($urandom_range(0, 255)));
                    wr_txn(8'h20, tx_buf.size());
                end
                2:       rd_txn(8'($urandom_range(0, 255)), int'($urandom_range(1, 3)));
                default: rd_cur(int'($urandom_range(1, 3)));
            endcase
        end

        // Reset while the target drives a 0 data bit (bit 7 of 0x5C).
        tx_buf = '{8'h0A, 8'h5C};
        wr_txn(8'h20, 2);
        bus_start();
        write_byte({DEV, 1'b0}, ack);
        write_byte(8'h0A, ack);
        bus_start();
        write_byte({DEV, 1'b1}, ack);
        check("mid_read_addr_ack", ack, I2C_ACK);
        waited = 0;
        while (!oe && waited < 20) begin
            ticks(1);
            waited++;
        end
        check("mid_read_oe_driven", oe, 1'b1);
        @(posedge i_clk); #2;
        i_rst = 1'b1;
        #1;
        check("reset_oe_async", oe, 1'b0);
        check("reset_regs", regs_flat, '0);
        check("reset_busy", busy, 1'b0);
        scl    = 1'b1;
        sda_tb = 1'b1;
        ticks(4);
        i_rst = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) mregs[k] = 8'h00;
        mptr = 0;
        ticks(8);

        // Decoding resumes normally; pointer starts at 0.
        rd_cur(1);
        tx_buf = '{8'h03, 8'hA5, 8'h3C};
        wr_txn(8'h20, 3);
        rd_txn(8'h03, 2);

        ticks(10);
        check("stb_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
